// File: rtl/mask_encoder16.sv
// Serial MSB-first encoder of a 16-bit thermometer mask into a leading-zero shift
// amount, flagging masks the left-shift mask decoder could never have produced.
module mask_encoder16 #(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  dout,
  output logic        err
);

  localparam int unsigned DW  = 16;
  localparam int unsigned IW  = 5;
  localparam int unsigned OW  = 4;
  localparam int unsigned ZW  = 5;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   sr_q, sr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [ZW-1:0]   zc_q, zc_d;
  logic            seen1_q, seen1_d;
  logic            bad_q, bad_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [OW-1:0]   dout_q, dout_d;
  logic            err_q, err_d;
  logic            b;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      idx_q       <= '0;
      zc_q        <= '0;
      seen1_q     <= 1'b0;
      bad_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      idx_q       <= idx_d;
      zc_q        <= zc_d;
      seen1_q     <= seen1_d;
      bad_q       <= bad_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic; handshake outputs are decoded from the next state
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    zc_d    = zc_q;
    seen1_d = seen1_q;
    bad_d   = bad_q;
    dout_d  = dout_q;
    err_d   = err_q;
    b       = sr_q[DW-1];

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sr_d    = din;
          idx_d   = '0;
          zc_d    = '0;
          seen1_d = 1'b0;
          bad_d   = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (b) begin
          seen1_d = 1'b1;
        end else if (!seen1_q) begin
          zc_d = zc_q + ZW'(1);
        end else begin
          bad_d = 1'b1;
        end
        sr_d  = {sr_q[DW-2:0], 1'b0};
        idx_d = idx_q + IW'(1);
        // Last bit: latch the result from the values updated this cycle
        if (idx_q == IW'(DW - 1)) begin
          state_d = DONE;
          dout_d  = zc_d[ZW-1] ? OW'(DW - 1) : zc_d[OW-1:0];
          err_d   = CHECK_EN && (bad_d || zc_d == ZW'(DW));
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign err       = err_q;

endmodule
